// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - actuated two-road traffic phase scheduler
//
// Sequences AR1 -> G1 -> Y1 -> AR2 -> G2 -> Y2 -> AR1 from vehicle demand,
// with min/max green, flash mode and a test-speed mode. Sole driver of the
// six lamp outputs.
//
// Optional feature macro: PED_WALK_EN (pedestrian walk phase in AR1).
//
// Ports:
//   CK            clock, rising edge
//   CLR           synchronous active-high reset
//   CAR1, CAR2    vehicle sensors, road 1 / road 2
//   FM            flash-mode request (level)
//   TEST          test speed, every dwell becomes 1 cycle
//   PED           pedestrian request (PED_WALK_EN only)
//   WALK          walk lamp (PED_WALK_EN only)
//   GRN1/YLW1/RED1, GRN2/YLW2/RED2  lamp outputs (registered)
//   STATE         current phase encoding
module traffic_phase_scheduler #(
  parameter int TW        = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YLW_T     = 3,
  parameter int ALLRED_T  = 2,
  parameter int FLASH_T   = 4
`ifdef PED_WALK_EN
  , parameter int WALK_T  = 6
`endif
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       CAR1,
  input  logic       CAR2,
  input  logic       FM,
  input  logic       TEST,
`ifdef PED_WALK_EN
  input  logic       PED,
  output logic       WALK,
`endif
  output logic       GRN1,
  output logic       YLW1,
  output logic       RED1,
  output logic       GRN2,
  output logic       YLW2,
  output logic       RED2,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    AR1   = 3'd0,
    G1    = 3'd1,
    Y1    = 3'd2,
    AR2   = 3'd3,
    G2    = 3'd4,
    Y2    = 3'd5,
    FLASH = 3'd6
  } phase_t;

  localparam logic [TW-1:0] ZERO  = '0;
  localparam logic [TW-1:0] ONE   = TW'(1);
  localparam logic [TW-1:0] AR_LD = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] Y_LD  = TW'(YLW_T - 1);
  localparam logic [TW-1:0] F_LD  = TW'(FLASH_T - 1);
  localparam logic [TW-1:0] G_MIN = TW'(GREEN_MIN);
  localparam logic [TW-1:0] G_MAX = TW'(GREEN_MAX);
`ifdef PED_WALK_EN
  localparam logic [TW-1:0] WK_LD  = TW'(ALLRED_T + WALK_T - 1);
  localparam logic [TW-1:0] WK_WIN = TW'(WALK_T);
`endif

  phase_t        st, st_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [TW-1:0] el, el_n;
  logic [TW-1:0] fcnt, fcnt_n;
  logic          dem1, dem1_n, dem2, dem2_n;
  logic          fph, fph_n;
`ifdef PED_WALK_EN
  logic          ped, ped_n;   // pedestrian request latch
  logic          wa, wa_n;     // current AR1 carries the walk interval
  logic          walk_n;
  logic [TW-1:0] wk_ld;
`endif

  // TEST collapses every dwell (and both green limits) to one cycle.
  logic [TW-1:0] ar_ld, y_ld, f_ld, g_min, g_max;
  assign ar_ld = TEST ? ZERO : AR_LD;
  assign y_ld  = TEST ? ZERO : Y_LD;
  assign f_ld  = TEST ? ZERO : F_LD;
  assign g_min = TEST ? ONE  : G_MIN;
  assign g_max = TEST ? ONE  : G_MAX;
`ifdef PED_WALK_EN
  assign wk_ld = TEST ? ZERO : WK_LD;
`endif

  assign STATE = st;

  // Lamp order: {GRN1, YLW1, RED1, GRN2, YLW2, RED2}
  function automatic logic [5:0] lamp_decode(input phase_t s, input logic ph);
    case (s)
      G1:      lamp_decode = 6'b100001;
      Y1:      lamp_decode = 6'b010001;
      G2:      lamp_decode = 6'b001100;
      Y2:      lamp_decode = 6'b001010;
      FLASH:   lamp_decode = {1'b0, ph, 4'b0000} | {5'b00000, ph};
      default: lamp_decode = 6'b001001;
    endcase
  endfunction

  always_comb begin
    st_n   = st;
    tmr_n  = (tmr == ZERO) ? tmr : tmr - ONE;
    el_n   = (el >= G_MAX) ? el : el + ONE;
    fcnt_n = fcnt;
    fph_n  = fph;
    // Demand latches set outside their own green; entry clear below wins.
    dem1_n = dem1 | (CAR1 && (st != G1));
    dem2_n = dem2 | (CAR2 && (st != G2));

    case (st)
      AR1: if (tmr == ZERO) begin
        if (FM) begin
          st_n = FLASH; fph_n = 1'b1; fcnt_n = f_ld;
        end else begin
          st_n = G1; el_n = ONE; dem1_n = 1'b0;
        end
      end
      // Elapsed is 1 in the first green cycle, so the limits equal dwell cycles.
      G1: if (FM || (dem2 && ((el >= g_max) || ((el >= g_min) && !CAR1)))) begin
        st_n = Y1; tmr_n = y_ld;
      end
      Y1: if (tmr == ZERO) begin
        st_n = AR2; tmr_n = ar_ld;
      end
      AR2: if (tmr == ZERO) begin
        if (FM) begin
          st_n = FLASH; fph_n = 1'b1; fcnt_n = f_ld;
        end else begin
          st_n = G2; el_n = ONE; dem2_n = 1'b0;
        end
      end
      G2: if (FM || (dem1 && ((el >= g_max) || ((el >= g_min) && !CAR2)))) begin
        st_n = Y2; tmr_n = y_ld;
      end
      Y2: if (tmr == ZERO) begin
        st_n = AR1; tmr_n = ar_ld;
      end
      FLASH: begin
        if (!FM) begin
          st_n = AR1; tmr_n = ar_ld;
        end else if (fcnt == ZERO) begin
          fph_n = ~fph; fcnt_n = f_ld;
        end else begin
          fcnt_n = fcnt - ONE;
        end
      end
      default: begin
        st_n = AR1; tmr_n = ar_ld;
      end
    endcase

`ifdef PED_WALK_EN
    // WALK is only ever high inside AR1, so this excludes the walk interval.
    ped_n  = ped | (PED && !WALK);
    wa_n   = wa;
    if ((st == AR1) && (tmr == ZERO)) begin
      if (wa || FM) ped_n = 1'b0;
      wa_n = 1'b0;
    end
    if ((st_n == AR1) && (st != AR1)) begin
      wa_n = ped_n;
      if (ped_n) tmr_n = wk_ld;
    end
    walk_n = (st_n == AR1) && wa_n && (tmr_n < WK_WIN);
`endif
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      st    <= AR1;
      tmr   <= AR_LD;
      el    <= ZERO;
      fcnt  <= ZERO;
      dem1  <= 1'b0;
      dem2  <= 1'b0;
      fph   <= 1'b0;
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} <= 6'b001001;
`ifdef PED_WALK_EN
      ped   <= 1'b0;
      wa    <= 1'b0;
      WALK  <= 1'b0;
`endif
    end else begin
      st    <= st_n;
      tmr   <= tmr_n;
      el    <= el_n;
      fcnt  <= fcnt_n;
      dem1  <= dem1_n;
      dem2  <= dem2_n;
      fph   <= fph_n;
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} <= lamp_decode(st_n, fph_n);
`ifdef PED_WALK_EN
      ped   <= ped_n;
      wa    <= wa_n;
      WALK  <= walk_n;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  logic       CK = 1'b0;
  logic       CLR = 1'b1, CAR1 = 1'b0, CAR2 = 1'b0, FM = 1'b0, TEST = 1'b0;
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
  logic [2:0] STATE;
`ifdef PED_WALK_EN
  logic       PED = 1'b0;
  logic       WALK;
`endif
  logic [5:0] lamps;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n;

  assign lamps = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};

  traffic_phase_scheduler dut (
    .CK(CK), .CLR(CLR), .CAR1(CAR1), .CAR2(CAR2), .FM(FM), .TEST(TEST),
`ifdef PED_WALK_EN
    .PED(PED), .WALK(WALK),
`endif
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .STATE(STATE)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
  endtask

  task automatic wait_st(input logic [2:0] s);
    int k = 0;
    while (STATE !== s && k < 100) begin
      tick(1);
      k++;
    end
    check("wait_state", STATE, s);
  endtask

  // Cycles remaining in state s, counted from the current sample.
  task automatic dur(input logic [2:0] s, output int cnt);
    cnt = 0;
    while (STATE === s && cnt < 200) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    // Reset from power-up, then mid-G2 reset
    tick(2);
    check("por_state", STATE, 0);
    check("por_lamps", lamps, 6'b001001);
    CLR = 1'b0;
    CAR2 = 1'b1;
    wait_st(3'd4);
    CLR = 1'b1;
    CAR2 = 1'b0;
    tick(2);
    check("rst_state", STATE, 0);
    check("rst_lamps", lamps, 6'b001001);
    CLR = 1'b0;
    tick(1);
    check("rst_grn1_early", GRN1, 0);
    tick(1);
    check("rst_grn1", GRN1, 1);
    check("rst_g1", STATE, 1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (STATE !== 3'd1) n++;
    end
    check("rest_g1", n, 0);

    // Minimum green
    do_reset();
    tick(2);
    check("min_g1_entry", STATE, 1);
    CAR2 = 1'b1;
    tick(1);
    CAR2 = 1'b0;
    dur(3'd1, n);
    check("min_g1_len", n + 1, 4);
    dur(3'd2, n);
    check("min_y1_len", n, 3);
    dur(3'd3, n);
    check("min_ar2_len", n, 2);
    check("min_g2_state", STATE, 4);
    check("min_g2_lamps", lamps, 6'b001100);

    // Maximum green
    do_reset();
    tick(1);
    CAR1 = 1'b1;
    tick(1);
    check("max_g1_entry", STATE, 1);
    CAR2 = 1'b1;
    tick(1);
    CAR2 = 1'b0;
    dur(3'd1, n);
    check("max_g1_len", n + 1, 12);
    dur(3'd2, n);
    check("max_y1_len", n, 3);
    dur(3'd3, n);
    check("max_ar2_len", n, 2);
    dur(3'd4, n);
    check("max_g2_len", n, 4);
    check("max_y2_state", STATE, 5);
    CAR1 = 1'b0;

    // Flash mode
    do_reset();
    tick(3);
    FM = 1'b1;
    tick(1);
    check("fl_y1_state", STATE, 2);
    check("fl_y1_lamps", lamps, 6'b010001);
    dur(3'd2, n);
    check("fl_y1_len", n, 3);
    dur(3'd3, n);
    check("fl_ar2_len", n, 2);
    check("fl_state", STATE, 6);
    for (int i = 0; i < 8; i++) begin
      check("fl_lamps", lamps, (i < 4) ? 6'b010001 : 6'b000000);
      tick(1);
    end
    check("fl_lamps_wrap", lamps, 6'b010001);
    FM = 1'b0;
    tick(1);
    check("fl_exit_ar1", STATE, 0);
    dur(3'd0, n);
    check("fl_ar1_len", n, 2);
    check("fl_g1", STATE, 1);

    // Test speed
    do_reset();
    TEST = 1'b1;
    CAR1 = 1'b1;
    CAR2 = 1'b1;
    wait_st(3'd1);
    for (int i = 0; i < 12; i++) begin
      check("ts_state", STATE, (i + 1) % 6);
      check("ts_road1", 32'(GRN1) + 32'(YLW1) + 32'(RED1), 1);
      check("ts_road2", 32'(GRN2) + 32'(YLW2) + 32'(RED2), 1);
      tick(1);
    end
    TEST = 1'b0;
    CAR1 = 1'b0;
    CAR2 = 1'b0;

`ifdef PED_WALK_EN
    // Pedestrian walk
    do_reset();
    check("ped_walk_rst", WALK, 0);
    CAR2 = 1'b1;
    wait_st(3'd4);
    CAR2 = 1'b0;
    CAR1 = 1'b1;
    PED = 1'b1;
    tick(1);
    PED = 1'b0;
    wait_st(3'd5);
    wait_st(3'd0);
    for (int i = 0; i < 8; i++) begin
      check("ped_ar1_state", STATE, 0);
      check("ped_walk", WALK, (i >= 2) ? 1 : 0);
      tick(1);
    end
    check("ped_g1", STATE, 1);
    check("ped_walk_off", WALK, 0);
    CAR1 = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Actuated phase scheduler for a two-road intersection (road 1 / road 2).
- Sequences green/yellow/all-red phases from vehicle-sensor demand, enforces minimum and maximum green times, and supports flash mode and test-speed mode.
- Drives the six lamp outputs directly. Sits above the lamp-latch/output-buffer stage as the single owner of the signal heads.

Parameters:
- TW, 8, width of the dwell timer and the elapsed-green counter.
- GREEN_MIN, 4, minimum green dwell in cycles (>=1).
- GREEN_MAX, 12, maximum green dwell in cycles when the other road has demand (>=GREEN_MIN).
- YLW_T, 3, yellow dwell in cycles (>=1).
- ALLRED_T, 2, all-red clearance dwell in cycles (>=1).
- FLASH_T, 4, half-period of flash blinking in cycles (>=1).

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset; one clock, synchronous, active-high; overrides every other input.
- CAR1  in  1  vehicle present on road 1.
- CAR2  in  1  vehicle present on road 2.
- FM  in  1  flash-mode request (level).
- TEST  in  1  test speed: every dwell is forced to 1 cycle.
- GRN1, YLW1, RED1  out  1 each  road 1 lamps.
- GRN2, YLW2, RED2  out  1 each  road 2 lamps.
- STATE  out  3  current phase encoding (debug).

Behaviour:
- States and STATE encoding: AR1=0 (all red, next is road 1), G1=1, Y1=2, AR2=3 (all red, next is road 2), G2=4, Y2=5, FLASH=6. Encoding 7 is illegal and recovers to AR1 on the next edge.
- Lamps are a Moore decode of the registered state. In each non-flash state exactly one lamp per road is on:
  - AR1, AR2: RED1=RED2=1.
  - G1: GRN1, RED2.
  - Y1: YLW1, RED2.
  - G2: RED1, GRN2.
  - Y2: RED1, YLW2.
- Reset (CLR=1 at an edge): state=AR1, RED1=RED2=1, all other lamps 0, STATE=0, demand latches 0, flash phase 0, dwell timer loaded with ALLRED_T-1, elapsed counter 0.
  - Mid-phase reset takes effect at that edge with no yellow completion.
- Dwell timer: loaded with (dwell-1) on state entry and decremented each cycle. A timed state exits on the edge where the timer is 0, so the state lasts exactly dwell cycles. With TEST=1 every dwell is 1.
- Sequence: AR1 -> G1 -> Y1 -> AR2 -> G2 -> Y2 -> AR1.
  - Y and AR states are purely timed.
- Green states:
  - The elapsed counter increments each cycle and saturates at GREEN_MAX.
  - G1 exits to Y1 when DEM2=1 and either elapsed >= GREEN_MAX, or elapsed >= GREEN_MIN and CAR1=0.
  - Without DEM2, G1 rests in green indefinitely. G2 is symmetric with DEM1 and CAR2.
- Demand latches:
  - DEM2 sets when CAR2=1 in any state other than G2, and clears on entry to G2.
  - DEM1 is symmetric (set outside G1, cleared on entry to G1).
  - Set and clear in the same cycle: clear wins.
- Flash mode:
  - FM=1 seen in G1/G2 forces the green exit (ignoring demand and minimum) and continues through yellow and all-red.
  - FM=1 in AR1/AR2 at timer expiry enters FLASH instead of the next green. Yellow is never truncated.
  - In FLASH: YLW1 = flash phase, RED2 = flash phase, all other lamps 0. Flash phase starts at 1 and toggles every FLASH_T cycles.
  - FM=0 in FLASH -> AR1 with a full ALLRED_T dwell.
- Simultaneous events: CLR > FM > demand/timers.

Optional Feature:
- Macro PED_WALK_EN.
- When defined, adds input PED (1) and output WALK (1), plus parameter WALK_T (default 6).
  - PED=1 sets a pedestrian latch in any state except AR1 while WALK=1.
  - If the latch is set when AR1 is entered, AR1 dwell becomes ALLRED_T+WALK_T. WALK=1 for the final WALK_T cycles of that AR1, and the latch clears on exit.
  - WALK=0 in all other states and after reset. FM entry from AR1 cancels the walk and clears the latch.
- When undefined: PED and WALK ports do not exist and AR1 dwell is always ALLRED_T.

Test Plan:
- Reset: CLR=1 for 2 cycles mid-G2 -> STATE=0, RED1=RED2=1, other lamps 0; CLR=0 with CAR1=CAR2=0 -> GRN1=1 exactly 2 cycles later, then rests in G1 (STATE=1) for 50 cycles.
- Min green: in G1 with CAR1=0, pulse CAR2 for 1 cycle at elapsed=1 -> G1 lasts exactly 4 cycles; Y1 lasts 3 cycles; AR2 lasts 2 cycles; then GRN2=1 with RED1=1.
- Max green: CAR1 held 1, CAR2 pulsed at entry of G1 -> G1 lasts exactly 12 cycles, then Y1; DEM1 set by held CAR1, so G2 exits after 4 cycles once CAR2=0.
- Flash: FM=1 at cycle 2 of G1 -> Y1 (3 cycles), AR2 (2 cycles), then FLASH: YLW1=RED2=1 for 4 cycles, 0 for 4 cycles, repeating; FM=0 -> AR1 for 2 cycles, then G1.
- TEST=1 with CAR1=CAR2=1 held -> every state lasts 1 cycle; STATE cycles 0,1,2,3,4,5,0; no cycle shows more than one lamp per road.
- PED_WALK_EN: PED pulse during G2, CAR1=1 -> Y2, then AR1 lasts 8 cycles with WALK=1 on cycles 3-8, then G1 and WALK=0.
